// File: rtl/spi_slave_regbank.sv
// SPI mode-0 slave with a byte-wide register bank, oversampled in the system clock domain.
// Frame: command byte {R/nW, addr[6:0]} then data bytes with auto-incrementing address.
module spi_slave_regbank #(
  parameter int unsigned NREGS     = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic                     host_we,
  input  logic [$clog2(NREGS)-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  output logic [7:0]               host_rdata,
  output logic                     wr_strobe,
  output logic [6:0]               wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int unsigned AW      = $clog2(NREGS);
  localparam logic [7:0]  NREGS_W = 8'(NREGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state, state_nx;
  logic [7:0]  regs [NREGS];

  logic        sclk_m, sclk_s, sclk_d;
  logic        cs_m, cs_s, cs_d;
  logic        mosi_m, mosi_s;
  logic [1:0]  sync_vld;
  logic        cs_armed;

  logic        rise, fall, start, active, byte_done;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, rx_next;
  logic [7:0]  tx_shift;
  logic        rw;
  logic [6:0]  addr;
  logic        wr_in_range;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_m   <= 1'b0;
      sclk_s   <= 1'b0;
      sclk_d   <= 1'b0;
      cs_m     <= 1'b1;
      cs_s     <= 1'b1;
      cs_d     <= 1'b1;
      mosi_m   <= 1'b0;
      mosi_s   <= 1'b0;
      sync_vld <= '0;
      cs_armed <= 1'b0;
    end else begin
      sclk_m   <= spi_sclk;
      sclk_s   <= sclk_m;
      sclk_d   <= sclk_s;
      cs_m     <= spi_cs_n;
      cs_s     <= cs_m;
      cs_d     <= cs_s;
      mosi_m   <= spi_mosi;
      mosi_s   <= mosi_m;
      sync_vld <= {sync_vld[0], 1'b1};
      // Preset synchronizer contents must not count as a CS_N high: a select
      // already low at reset release only arms after the pin is really seen high.
      cs_armed <= cs_armed | (sync_vld[1] & cs_s);
    end
  end

  always_comb begin
    rise        = sclk_s & ~sclk_d;
    fall        = ~sclk_s & sclk_d;
    start       = (state == IDLE) & cs_armed & cs_d & ~cs_s;
    active      = (state != IDLE) & ~cs_s;
    rx_next     = {rx_shift[6:0], mosi_s};
    byte_done   = active & rise & (bit_cnt == 3'd7);
    wr_in_range = {1'b0, addr} < NREGS_W;
    rd_addr     = (state == CMD) ? rx_next[6:0] : addr + 7'd1;
    rd_data     = ({1'b0, rd_addr} < NREGS_W) ? regs[rd_addr[AW-1:0]] : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CMD;
      CMD: begin
        if (cs_s)           state_nx = IDLE;
        else if (byte_done) state_nx = DATA;
      end
      DATA: if (cs_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rw          <= 1'b0;
      addr        <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      spi_miso_oe <= ~cs_s;
      wr_strobe   <= 1'b0;
      // Host write first so a same-cycle SPI write to the same register overrides it.
      if (host_we) regs[host_addr] <= host_wdata;
      if (start) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        spi_miso <= 1'b0;
      end else if (!active) begin
        spi_miso <= 1'b0;
      end else if (rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_next;
        if (bit_cnt == 3'd7) begin
          if (state == CMD) begin
            rw   <= rx_next[7];
            addr <= rx_next[6:0];
            if (rx_next[7]) tx_shift <= rd_data;
          end else begin
            if (!rw && wr_in_range) begin
              regs[addr[AW-1:0]] <= rx_next;
              wr_strobe          <= 1'b1;
              wr_addr            <= addr;
              wr_data            <= rx_next;
            end
            if (rw) tx_shift <= rd_data;
            addr <= addr + 7'd1;
          end
        end
      end else if (fall) begin
        if ((state == DATA) && rw) begin
          spi_miso <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end else begin
          spi_miso <= 1'b0;
        end
      end
    end
  end

  assign host_rdata = regs[host_addr];
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed and randomized bench for spi_slave_regbank: a bit-banged SPI master plus a
// register-array model that predicts read bytes, register contents and write strobes.
module tb_spi_slave_regbank;

  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;

  logic          clock;
  logic          reset_n;
  logic          spi_sclk, spi_cs_n, spi_mosi;
  logic          spi_miso, spi_miso_oe;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata, host_rdata;
  logic          wr_strobe;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  spi_slave_regbank #(.NREGS(NREGS), .RESET_VAL(8'h00)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  int unsigned strobe_cnt = 0;
  logic [6:0]  stb_addr = '0;
  logic [7:0]  stb_data = '0;
  logic [7:0]  mdl    [NREGS];
  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];

  always @(negedge clock) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      stb_addr   <= wr_addr;
      stb_data   <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hread(input logic [AW-1:0] a, input string tag);
    host_addr = a;
    #1;
    check(tag, host_rdata, mdl[a]);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clock);
    host_we = 1'b0;
    mdl[a] = d;
  endtask

  // One SPI bit, 4 system clocks per SCLK phase; MISO sampled just before the rising edge.
  // hw fires a one-cycle host write aligned with the clock that acts on this rising edge.
  task automatic spi_bit(input logic b, input logic hw, input logic [AW-1:0] ha,
                         input logic [7:0] hd, output logic r);
    spi_mosi = b;
    repeat (4) @(negedge clock);
    r = spi_miso;
    spi_sclk = 1'b1;
    if (hw) begin
      repeat (2) @(negedge clock);
      host_we = 1'b1; host_addr = ha; host_wdata = hd;
      @(negedge clock);
      host_we = 1'b0;
      @(negedge clock);
    end else begin
      repeat (4) @(negedge clock);
    end
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic hw, input logic [AW-1:0] ha,
                          input logic [7:0] hd, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], hw && (i == 0), ha, hd, r[i]);
  endtask

  // Full frame of tx_buf[0..n-1]; expectations come from walking the address sequence over mdl.
  task automatic run_frame(input int unsigned n, input string tag);
    int unsigned s0, nexp;
    logic        rwm;
    logic [6:0]  a, la;
    logic [7:0]  ld, exp_rd;
    s0 = strobe_cnt; nexp = 0; la = '0; ld = '0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
    for (int unsigned k = 0; k < n; k++) begin
      spi_byte(tx_buf[k], 1'b0, '0, '0, rx_buf[k]);
      if (k == 0) begin
        check({tag, "_busy_hi"}, busy, 1);
        check({tag, "_oe_hi"}, spi_miso_oe, 1);
      end
    end
    repeat (4) @(negedge clock);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clock);
    check({tag, "_busy_lo"}, busy, 0);
    check({tag, "_oe_lo"}, spi_miso_oe, 0);
    rwm = tx_buf[0][7];
    a   = tx_buf[0][6:0];
    check({tag, "_cmd_miso"}, rx_buf[0], 0);
    for (int unsigned k = 1; k < n; k++) begin
      if (rwm) begin
        exp_rd = (int'(a) < NREGS) ? mdl[a[AW-1:0]] : 8'h00;
      end else begin
        exp_rd = 8'h00;
        if (int'(a) < NREGS) begin
          mdl[a[AW-1:0]] = tx_buf[k];
          nexp++; la = a; ld = tx_buf[k];
        end
      end
      check({tag, "_miso"}, rx_buf[k], exp_rd);
      a = a + 7'd1;
    end
    check({tag, "_nstb"}, strobe_cnt - s0, nexp);
    if (nexp > 0) begin
      check({tag, "_wr_addr"}, stb_addr, la);
      check({tag, "_wr_data"}, stb_data, ld);
    end
  endtask

  initial begin
    int unsigned s0, n;
    logic [7:0]  r, keep3;
    logic [6:0]  a7;

    reset_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) mdl[i] = 8'h00;

    // Reset held with random SPI activity
    for (int unsigned i = 0; i < NREGS; i++) begin
      @(negedge clock);
      spi_sclk = 1'($urandom); spi_cs_n = 1'($urandom); spi_mosi = 1'($urandom);
      hread(AW'(i), "rst_rdata");
      check("rst_miso", spi_miso, 0);
      check("rst_oe", spi_miso_oe, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
    end
    @(negedge clock);
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);

    // Single write
    tx_buf[0] = 8'h05; tx_buf[1] = 8'hA5;
    run_frame(2, "wr1");
    check("wr1_stb_addr", stb_addr, 7'd5);
    check("wr1_stb_data", stb_data, 8'hA5);
    host_addr = 4'd5; #1;
    check("wr1_rdata", host_rdata, 8'hA5);

    // Burst read running off the end of the bank
    @(negedge clock);
    host_write(4'd14, 8'h11);
    host_write(4'd15, 8'h22);
    tx_buf[0] = 8'h8E; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    run_frame(4, "rdwrap");
    check("rdwrap_b0", rx_buf[1], 8'h11);
    check("rdwrap_b1", rx_buf[2], 8'h22);
    check("rdwrap_b2", rx_buf[3], 8'h00);

    // Aborted frame then a complete one
    keep3 = mdl[3];
    s0 = strobe_cnt;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
    spi_byte(8'h03, 1'b0, '0, '0, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, '0, '0, r[0]);
    repeat (4) @(negedge clock);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clock);
    check("abort_nstb", strobe_cnt - s0, 0);
    check("abort_busy", busy, 0);
    host_addr = 4'd3; #1;
    check("abort_reg3", host_rdata, keep3);
    @(negedge clock);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h5A;
    run_frame(2, "after_abort");
    host_addr = 4'd3; #1;
    check("after_abort_reg3", host_rdata, 8'h5A);

    // Host and SPI writes in the same clock: same register, then different registers
    for (int unsigned c = 0; c < 2; c++) begin
      logic [3:0] spi_a, host_a;
      logic [7:0] spi_d;
      spi_a  = (c == 0) ? 4'd7 : 4'd8;
      spi_d  = (c == 0) ? 8'h3C : 8'h4D;
      host_a = (c == 0) ? 4'd7 : 4'd2;
      @(negedge clock);
      s0 = strobe_cnt;
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clock);
      spi_byte({4'h0, spi_a}, 1'b0, '0, '0, r);
      spi_byte(spi_d, 1'b1, host_a, (c == 0) ? 8'hFF : 8'h99, r);
      repeat (4) @(negedge clock);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clock);
      if (c != 0) mdl[host_a] = 8'h99;
      mdl[spi_a] = spi_d;
      check("coll_nstb", strobe_cnt - s0, 1);
      check("coll_stb_addr", stb_addr, {3'b0, spi_a});
      check("coll_stb_data", stb_data, spi_d);
      hread(spi_a, "coll_spi_reg");
      hread(host_a, "coll_host_reg");
    end

    // Randomized frames interleaved with host writes
    for (int unsigned t = 0; t < 24; t++) begin
      @(negedge clock);
      if ($urandom_range(0, 1) == 1) host_write(AW'($urandom_range(0, NREGS - 1)), 8'($urandom));
      n  = $urandom_range(2, 5);
      a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 19));
      tx_buf[0] = {1'($urandom_range(0, 1)), a7};
      for (int unsigned k = 1; k < 8; k++) tx_buf[k] = 8'($urandom);
      run_frame(n, "rnd");
    end
    for (int unsigned i = 0; i < NREGS; i++) hread(AW'(i), "rnd_final");

    // Reset in the middle of a write data byte; the frame continues after release
    @(negedge clock);
    s0 = strobe_cnt;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
    spi_byte(8'h09, 1'b0, '0, '0, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, '0, '0, r[0]);
    reset_n = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) mdl[i] = 8'h00;
    @(negedge clock);
    check("mrst_busy", busy, 0);
    check("mrst_miso", spi_miso, 0);
    check("mrst_wr_addr", wr_addr, 0);
    for (int unsigned i = 0; i < NREGS; i++) hread(AW'(i), "mrst_regs");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, '0, '0, r[0]);
    spi_byte(8'h77, 1'b0, '0, '0, r);
    repeat (4) @(negedge clock);
    check("mrst_ignored_busy", busy, 0);
    check("mrst_nstb", strobe_cnt - s0, 0);
    hread(4'd9, "mrst_reg9");
    hread(4'd10, "mrst_reg10");
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clock);
    tx_buf[0] = 8'h09; tx_buf[1] = 8'hC3;
    run_frame(2, "post_rst");
    hread(4'd9, "post_rst_reg9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_regbank.md
Name: spi_slave_regbank

Overview:
- SPI mode-0 slave with a small byte-wide register bank.
- Sits on the far end of the SoC's SPI1 pads (gpio[19..23]) and answers SPI master transactions.
- Used as a synthesizable bench responder and as a reusable peripheral model.
- Oversamples SCLK/CS_N/MOSI in the system clock domain; exposes a host-side port for local register access and a write-event strobe.

Parameters:
- NREGS, 16, number of 8-bit registers (power of 2, 2..128).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clock  input  1  system clock; must be >= 8x SCLK frequency.
- reset_n  input  1  asynchronous active-low reset.
- spi_sclk  input  1  SPI clock from master, idle low (CPOL=0).
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data.
- spi_miso_oe  output  1  MISO output enable (pad tristate control).
- host_we  input  1  host write strobe.
- host_addr  input  $clog2(NREGS)  host read/write address.
- host_wdata  input  8  host write data.
- host_rdata  output  8  combinational read of regs[host_addr].
- wr_strobe  output  1  one-cycle pulse per completed SPI register write.
- wr_addr  output  7  address of last SPI write.
- wr_data  output  8  data of last SPI write.
- busy  output  1  high while a transaction is active (synced CS_N low).

Behaviour:
- Reset (async, reset_n=0):
  - regs = RESET_VAL.
  - spi_miso=0, spi_miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - FSM=IDLE; synchronizers preset to idle (sclk=0, cs_n=1).
- Input synchronization:
  - 2-flop synchronizer per SPI input, plus one history flop on sclk.
  - rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d.
  - Input-to-action latency: 2-3 clocks.
- Frame format, MSB first, 8-bit bytes:
  - byte0 = command: bit7 = R/nW, bits[6:0] = addr.
  - byte1..N = data.
  - Address auto-increments after each data byte, 7-bit wrap 0x7F->0x00.
- Sampling: MOSI sampled on rise; MISO updated on fall; bit counter 0..7.
- FSM:
  - IDLE: when cs_n_s falls, clear shift regs and bit count -> CMD.
  - CMD: after 8th rise, latch rw and addr -> DATA.
    - If read, load tx_shift = rd(addr); bit7 is driven at the next fall, which precedes the 9th rise.
  - DATA: after each 8th rise:
    - Write: if addr < NREGS, regs[addr] <= rx byte and pulse wr_strobe with wr_addr/wr_data; otherwise discard with no strobe.
    - Then addr++.
    - Read: reload tx_shift = rd(addr+1) for the next byte.
  - Any state: cs_n_s high -> IDLE next clock; partial byte discarded, no write, no strobe.
- Out-of-range read (addr >= NREGS) returns 8'h00.
- MISO during CMD and during write-data bytes = 0.
- spi_miso_oe = ~cs_n_s, registered; busy = (state != IDLE).
- Host write vs SPI write completing to the same register in the same clock: SPI wins. Different registers both update.
- Host read is combinational and unaffected by SPI activity.
- Read-data sampling: a host write to the read address after tx_shift is loaded does not change bits already being shifted.
- reset_n asserted mid-transaction: immediate return to reset state. After release the FSM waits in IDLE for a fresh CS_N falling edge; a CS_N already low at release is ignored until it goes high then low.
- SCLK edges while CS_N is high are ignored.

Test Plan:
- Reset: hold reset_n=0 with random SPI inputs -> all outputs 0, host_rdata=8'h00 for all addresses.
- Single write: CS low, send 0x05, 0xA5, CS high -> regs[5]=0xA5; one wr_strobe with wr_addr=5, wr_data=0xA5; host_rdata@5=0xA5.
- Burst read with wrap: host writes regs[14]=0x11 and regs[15]=0x22 (NREGS=16). Master sends 0x8E then three dummy bytes.
  - Required MISO: 0x11, 0x22, then 0x00 (addr 16, out of range).
  - Required: no wr_strobe.
- Aborted frame: CS low, 0x03, 4 bits of data, CS high -> regs[3] unchanged, no strobe. Next full frame 0x03, 0x5A writes 0x5A.
- Collision: SPI write 0x07/0x3C completes in the same clock as host_we to addr 7 with 0xFF -> regs[7]=0x3C.
- Mid-transaction reset: pulse reset_n low during byte1 of a write.
  - Required: regs=RESET_VAL, no strobe.
  - Required: the frame continuing after release (CS still low) is ignored until CS toggles.
